load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of ACCESS cycles before a fault is raised (used only with LSU_TIMEOUT_EN).
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_we_i in 1 (1=store), req_func3_i in 3, req_addr_i in ADDR_WIDTH, req_wdata_i in DATA_WIDTH; pipeline request channel.
REQ-007 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDR_WIDTH (bits [2:0] always zero), mem_wdata_o out DATA_WIDTH, mem_be_o out 8, mem_ack_i in 1, mem_rdata_i in DATA_WIDTH; data-memory channel.
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_data_o out DATA_WIDTH (raw, unaligned word), rsp_offset_o out 3, rsp_func3_o out 3; response to the downstream load-extract stage.
REQ-009 SHALL have ports store_addr_ma_o out 1 (misaligned store) and access_fault_o out 1 (timeout fault).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-011 IDLE: req_ready_o=1; on req_valid_i=1 SHALL latch we, func3, addr, wdata; go to ACCESS, or to RESP without memory access when the store is misaligned.
REQ-012 Store misalignment: SB never; SH addr[0]; SW |addr[1:0]; SD |addr[2:0]; store func3[2] ignored (func3 & 3'b011).
REQ-013 Loads SHALL NOT be checked for alignment here; they always access memory.
REQ-014 ACCESS: mem_req_o=1 with stable mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o until the cycle mem_ack_i=1 is sampled; then go to RESP and capture mem_rdata_i (loads only).
REQ-015 mem_ack_i SHALL be ignored outside ACCESS.
REQ-016 mem_addr_o = {addr[ADDR_WIDTH-1:3], 3'b000}.
REQ-017 Store byte enables: SB 1 bit at offset, SH 2 bits at offset, SW 4 bits at offset, SD 8'hFF; mem_wdata_o holds the low store bytes replicated into every lane of their size; loads drive mem_be_o=8'h00.
REQ-018 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; req_ready_o=0 in ACCESS and RESP.
REQ-019 rsp_offset_o=addr[2:0] and rsp_func3_o=latched func3, valid with rsp_valid_o; rsp_data_o=captured data for loads, zero for stores.
REQ-020 store_addr_ma_o and access_fault_o SHALL be valid only while rsp_valid_o=1 and zero otherwise.
REQ-021 Latency: request accepted at edge N, mem_req_o high from cycle N+1, ack sampled at edge N+k, rsp_valid_o high in cycle N+k+1; misaligned store: rsp_valid_o in cycle N+1.
REQ-022 Back-to-back: a new request SHALL be accepted no earlier than the cycle after RESP (one accepted request in flight at a time).

Reset
REQ-023 On rst_ni=0 at a clock edge, state SHALL become IDLE and all outputs SHALL become zero except req_ready_o=1, including mid-ACCESS (any in-flight access is abandoned; a late ack is ignored).

Configuration
REQ-024 With LSU_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle; when it reaches TIMEOUT_CYCLES without ack, go to RESP with access_fault_o=1 and rsp_data_o=0.
REQ-025 With LSU_TIMEOUT_EN, an ack sampled in the expiry cycle SHALL win (normal response, no fault).
REQ-026 Without LSU_TIMEOUT_EN, no counter SHALL exist, access_fault_o SHALL be tied 0, and ACCESS waits indefinitely.

Structure
REQ-027 Package lsu_pkg SHALL hold the FSM state enum and func3 constants (SB/SH/SW/SD, LB..LWU).
REQ-028 Sub-module store_align SHALL combinationally produce mem_be_o and mem_wdata_o from func3, offset and wdata.

Verification
REQ-029 LD addr 0x1008, ack after 3 cycles, rdata 0xDEADBEEF_01234567 -> mem_addr_o 0x1008, rsp_data_o same value, rsp_offset_o 0, rsp_valid_o one cycle.
REQ-030 SH addr 0x2006, wdata 0xABCD -> mem_be_o 8'hC0, mem_wdata_o[63:48]=0xABCD, mem_addr_o 0x2000, store_addr_ma_o=0.
REQ-031 SW addr 0x2002 -> no mem_req_o, rsp_valid_o next cycle with store_addr_ma_o=1.
REQ-032 LB addr 0x3005, rst_ni=0 while in ACCESS, then ack -> IDLE, req_ready_o=1, no rsp_valid_o.
REQ-033 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> access_fault_o=1 with rsp_valid_o after 4 ACCESS cycles; ack on the 4th cycle -> no fault.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   * lsu_state_e        : FSM states of load_store_unit
//   * F3_*               : func3 encodings for loads and stores
//   * SIZE_*             : access size field (func3[1:0])
//   * store_misaligned() : store alignment check on func3 and address offset
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Store func3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Load func3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Access size; func3[2] only selects sign handling, which stores ignore.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  function automatic logic store_misaligned(input logic [2:0] func3,
                                            input logic [2:0] offset);
    logic mis;
    mis = 1'b0;
    case (func3[1:0])
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = offset[0];
      SIZE_W:  mis = |offset[1:0];
      default: mis = |offset[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_align.sv
// store_align -- combinational store lane alignment.
//   size   in  2           access size (func3[1:0])
//   offset in  3           byte offset within the 64-bit word
//   wdata  in  DATA_WIDTH  store data, least-significant bytes used
//   be     out 8           byte enables shifted to the offset
//   lanes  out DATA_WIDTH  low store bytes replicated into every lane of their size
module store_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [1:0]            size,
  input  logic [2:0]            offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [7:0]            be,
  output logic [DATA_WIDTH-1:0] lanes
);

  localparam int LANES = DATA_WIDTH / 8;

  always_comb begin
    be = 8'h00;
    case (size)
      SIZE_B:  be = 8'b0000_0001 << offset;
      SIZE_H:  be = 8'b0000_0011 << offset;
      SIZE_W:  be = 8'b0000_1111 << offset;
      default: be = 8'hFF;
    endcase
  end

  // Replication means the memory only has to honour be; whichever lanes are
  // enabled already carry the right bytes.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_comb begin
        lanes[gi*8 +: 8] = wdata[7:0];
        case (size)
          SIZE_B:  lanes[gi*8 +: 8] = wdata[7:0];
          SIZE_H:  lanes[gi*8 +: 8] = wdata[(gi % 2)*8 +: 8];
          SIZE_W:  lanes[gi*8 +: 8] = wdata[(gi % 4)*8 +: 8];
          default: lanes[gi*8 +: 8] = wdata[(gi % 8)*8 +: 8];
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store unit (IDLE -> ACCESS -> RESP).
//   clk_i, rst_ni           clock; synchronous active-low reset
//   req_*                   request channel from the pipeline (ready only in IDLE)
//   mem_*                   data-memory channel (word-aligned address, byte enables)
//   rsp_*                   one-cycle response with raw word, offset and func3
//   store_addr_ma_o         misaligned store flag (valid with rsp_valid_o)
//   access_fault_o          access timeout flag (valid with rsp_valid_o)
// Optional feature: define LSU_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// cycles without ack; otherwise ACCESS waits forever and access_fault_o is 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_func3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [7:0]            mem_be_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [2:0]            rsp_offset_o,
  output logic [2:0]            rsp_func3_o,
  output logic                  store_addr_ma_o,
  output logic                  access_fault_o
);

  lsu_state_e            state_reg, state_next;
  logic                  we_reg;
  logic [2:0]            func3_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  ma_reg;

  logic                  in_access, in_resp;
  logic                  accept, req_mis, timeout_hit;
  logic [7:0]            align_be;
  logic [DATA_WIDTH-1:0] align_lanes;

  assign in_access = (state_reg == ACCESS);
  assign in_resp   = (state_reg == RESP);
  assign accept    = (state_reg == IDLE) && req_valid_i;
  assign req_mis   = req_we_i && store_misaligned(req_func3_i, req_addr_i[2:0]);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid_i) state_next = req_mis ? RESP : ACCESS;
      ACCESS:  if (mem_ack_i || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_reg    <= 1'b0;
      func3_reg <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ma_reg    <= 1'b0;
    end else if (accept) begin
      we_reg    <= req_we_i;
      func3_reg <= req_func3_i;
      addr_reg  <= req_addr_i;
      wdata_reg <= req_wdata_i;
      rdata_reg <= '0;
      ma_reg    <= req_mis;
    end else if (in_access && mem_ack_i && !we_reg) begin
      // An ack in the expiry cycle still delivers data.
      rdata_reg <= mem_rdata_i;
    end
  end

  // ---------------------------------------------------------------- timeout
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tcnt_reg;
  logic             fault_reg;

  // Held at zero outside ACCESS, so it is clear on every ACCESS entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !in_access) tcnt_reg <= '0;
    else                       tcnt_reg <= tcnt_reg + CNT_W'(1);
  end

  // True in the last permitted ACCESS cycle.
  assign timeout_hit = in_access && (tcnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || accept) fault_reg <= 1'b0;
    else if (timeout_hit && !mem_ack_i) fault_reg <= 1'b1;
  end

  assign access_fault_o = in_resp && fault_reg;
`else
  assign timeout_hit    = 1'b0;
  assign access_fault_o = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  store_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_store_align (
    .size  (func3_reg[1:0]),
    .offset(addr_reg[2:0]),
    .wdata (wdata_reg),
    .be    (align_be),
    .lanes (align_lanes)
  );

  assign req_ready_o     = (state_reg == IDLE);
  assign mem_req_o       = in_access;
  assign mem_we_o        = in_access && we_reg;
  assign mem_addr_o      = in_access ? {addr_reg[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign mem_be_o        = (in_access && we_reg) ? align_be : 8'h00;
  assign mem_wdata_o     = (in_access && we_reg) ? align_lanes : '0;

  assign rsp_valid_o     = in_resp;
  assign rsp_data_o      = in_resp ? rdata_reg : '0;
  assign rsp_offset_o    = in_resp ? addr_reg[2:0] : 3'b000;
  assign rsp_func3_o     = in_resp ? func3_reg : 3'b000;
  assign store_addr_ma_o = in_resp && ma_reg;

endmodule
